// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button-driven run/pause/clear/set control, count-tick prescaler and digit load strobes.
// Optional lap/display-hold behaviour is enabled by defining LAP_EN.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV    = 100,
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DIGIT_MAX   = 9,
  parameter int unsigned STOP_ON_OVF = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          btn_start,
  input  logic                          btn_clear,
  input  logic                          btn_set,
  input  logic                          btn_next,
  input  logic                          btn_inc,
  input  logic                          ovf_in,
  output logic                          count_en,
  output logic                          clr,
  output logic                          load_stb,
  output logic [NUM_DIGITS-1:0]         load_sel,
  output logic [3:0]                    load_val,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_ptr,
  output logic [1:0]                    state,
  output logic                          disp_hold
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] PTR_LAST   = DW'(NUM_DIGITS - 1);
  localparam logic [3:0]    EDIT_MAX   = 4'(DIGIT_MAX);
  localparam logic          OVF_STOP   = (STOP_ON_OVF != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_SET   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic                    count_en_q, count_en_d;
  logic                    clr_q, clr_d;
  logic                    load_stb_q, load_stb_d;
  logic [NUM_DIGITS-1:0]   load_sel_q, load_sel_d;
  logic [3:0]              load_val_q, load_val_d;
  logic [DW-1:0]           digit_ptr_q, digit_ptr_d;
  logic [3:0]              edit_q, edit_d;
`ifdef LAP_EN
  logic                    hold_q, hold_d;
`endif

  // Each state walks its own priority chain, so an event that is ignored in
  // the current state never masks a lower-priority one that does act.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    count_en_d  = 1'b0;
    clr_d       = 1'b0;
    load_stb_d  = 1'b0;
    load_sel_d  = '0;
    load_val_d  = '0;
    digit_ptr_d = digit_ptr_q;
    edit_d      = edit_q;
`ifdef LAP_EN
    hold_d      = hold_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (btn_clear) begin
          clr_d   = 1'b1;
          presc_d = '0;
`ifdef LAP_EN
          hold_d  = 1'b0;
`endif
        end else if (btn_set) begin
          state_d     = S_SET;
          digit_ptr_d = '0;
          edit_d      = '0;
`ifdef LAP_EN
          hold_d      = 1'b0;
`endif
        end else if (btn_start) begin
          state_d = S_RUN;
          presc_d = '0;
        end
      end
      S_RUN: begin
        if (btn_clear) begin
          clr_d   = 1'b1;
          presc_d = '0;
          state_d = S_IDLE;
`ifdef LAP_EN
          hold_d  = 1'b0;
`endif
        end else if (btn_start || (OVF_STOP && ovf_in)) begin
          state_d = S_PAUSE;
        end else begin
          if (presc_q == PRESC_LAST) begin
            presc_d    = '0;
            count_en_d = 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
`ifdef LAP_EN
          if (btn_next) hold_d = ~hold_q;
`endif
        end
      end
      S_PAUSE: begin
        if (btn_clear) begin
          clr_d   = 1'b1;
          presc_d = '0;
          state_d = S_IDLE;
`ifdef LAP_EN
          hold_d  = 1'b0;
`endif
        end else if (btn_set) begin
          state_d     = S_SET;
          digit_ptr_d = '0;
          edit_d      = '0;
`ifdef LAP_EN
          hold_d      = 1'b0;
`endif
        end else if (btn_start) begin
          state_d = S_RUN;
        end
      end
      S_SET: begin
        if (btn_clear) begin
          edit_d = '0;
`ifdef LAP_EN
          hold_d = 1'b0;
`endif
        end else if (btn_set) begin
          state_d = S_PAUSE;
        end else if (btn_next) begin
          load_stb_d  = 1'b1;
          load_sel_d  = NUM_DIGITS'(1) << digit_ptr_q;
          load_val_d  = edit_q;
          digit_ptr_d = (digit_ptr_q == PTR_LAST) ? '0 : digit_ptr_q + 1'b1;
          edit_d      = '0;
        end else if (btn_inc) begin
          edit_d = (edit_q == EDIT_MAX) ? '0 : edit_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      count_en_q  <= 1'b0;
      clr_q       <= 1'b0;
      load_stb_q  <= 1'b0;
      load_sel_q  <= '0;
      load_val_q  <= '0;
      digit_ptr_q <= '0;
      edit_q      <= '0;
`ifdef LAP_EN
      hold_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      count_en_q  <= count_en_d;
      clr_q       <= clr_d;
      load_stb_q  <= load_stb_d;
      load_sel_q  <= load_sel_d;
      load_val_q  <= load_val_d;
      digit_ptr_q <= digit_ptr_d;
      edit_q      <= edit_d;
`ifdef LAP_EN
      hold_q      <= hold_d;
`endif
    end
  end

  assign count_en  = count_en_q;
  assign clr       = clr_q;
  assign load_stb  = load_stb_q;
  assign load_sel  = load_sel_q;
  assign load_val  = load_val_q;
  assign digit_ptr = digit_ptr_q;
  assign state     = state_q;
`ifdef LAP_EN
  assign disp_hold = hold_q;
`else
  assign disp_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (TICK_DIV=4, NUM_DIGITS=4); honours LAP_EN when defined.
module tb_stopwatch_ctrl;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2, ST_SET = 2'd3;
  localparam logic [2:0] K_CE = 3'b100, K_CLR = 3'b010, K_LD = 3'b001;
  localparam logic [5:0] B_START = 6'b100000, B_CLEAR = 6'b010000, B_SET = 6'b001000,
                         B_NEXT  = 6'b000100, B_INC   = 6'b000010, B_OVF = 6'b000001;
`ifdef LAP_EN
  localparam logic LAP = 1'b1;
`else
  localparam logic LAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_start = 1'b0, btn_clear = 1'b0, btn_set = 1'b0;
  logic btn_next = 1'b0, btn_inc = 1'b0, ovf_in = 1'b0;
  logic       count_en, clr, load_stb, disp_hold;
  logic [3:0] load_sel, load_val;
  logic [1:0] digit_ptr, state;

  stopwatch_ctrl #(
    .TICK_DIV(4), .NUM_DIGITS(4), .DIGIT_MAX(9), .STOP_ON_OVF(1)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .btn_clear(btn_clear), .btn_set(btn_set),
    .btn_next(btn_next), .btn_inc(btn_inc), .ovf_in(ovf_in),
    .count_en(count_en), .clr(clr), .load_stb(load_stb),
    .load_sel(load_sel), .load_val(load_val), .digit_ptr(digit_ptr),
    .state(state), .disp_hold(disp_hold)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [2:0] kind; logic [3:0] sel; logic [3:0] val; } strobe_t;
  typedef struct { int cyc; logic [1:0] st; logic [1:0] ptr; logic chk_ptr; logic hold; logic chk_zero; } snap_t;

  strobe_t exp_q[$];
  snap_t   snap_q[$];
  int checks = 0;
  int failures = 0;
  logic finish_req = 1'b0;
  logic done = 1'b0;

  function automatic void exp_strobe(int c, logic [2:0] k, logic [3:0] s, logic [3:0] v);
    strobe_t e;
    e.cyc = c; e.kind = k; e.sel = s; e.val = v;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_snap(int c, logic [1:0] st, logic [1:0] p, logic cp, logic h, logic cz);
    snap_t s;
    s.cyc = c; s.st = st; s.ptr = p; s.chk_ptr = cp; s.hold = h; s.chk_zero = cz;
    snap_q.push_back(s);
  endfunction

  // Monitor: every strobe the DUT raises is matched against the next expected one.
  always @(negedge clk) begin
    strobe_t es;
    snap_t   ss;
    if (count_en || clr || load_stb) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL strobe_unexpected cyc=%0d got {ce,clr,ld}=%b required none", cyc, {count_en, clr, load_stb});
      end else begin
        es = exp_q.pop_front();
        if ({count_en, clr, load_stb} !== es.kind || es.cyc != cyc ||
            (es.kind == K_LD && (load_sel !== es.sel || load_val !== es.val))) begin
          failures++;
          $display("FAIL strobe got cyc=%0d kind=%b sel=%b val=%0d required cyc=%0d kind=%b sel=%b val=%0d",
                   cyc, {count_en, clr, load_stb}, load_sel, load_val, es.cyc, es.kind, es.sel, es.val);
        end
      end
    end
    while (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
      ss = snap_q.pop_front();
      checks++;
      if (state !== ss.st || disp_hold !== ss.hold || (ss.chk_ptr && digit_ptr !== ss.ptr) ||
          (ss.chk_zero && (load_sel !== 4'b0 || load_val !== 4'b0 || count_en !== 1'b0 || clr !== 1'b0 || load_stb !== 1'b0))) begin
        failures++;
        $display("FAIL snapshot cyc=%0d got state=%0d ptr=%0d hold=%b sel=%b val=%0d required state=%0d ptr=%0d hold=%b",
                 cyc, state, digit_ptr, disp_hold, load_sel, load_val, ss.st, ss.ptr, ss.hold);
      end
    end
    if (finish_req && !done) begin
      while (exp_q.size() != 0) begin
        es = exp_q.pop_front();
        checks++; failures++;
        $display("FAIL strobe_missing got none required cyc=%0d kind=%b", es.cyc, es.kind);
      end
      while (snap_q.size() != 0) begin
        ss = snap_q.pop_front();
        checks++; failures++;
        $display("FAIL snapshot_missing got none required cyc=%0d state=%0d", ss.cyc, ss.st);
      end
      done = 1'b1;
    end
  end

  task automatic press(input logic [5:0] b);
    {btn_start, btn_clear, btn_set, btn_next, btn_inc, ovf_in} = b;
    @(negedge clk);
    {btn_start, btn_clear, btn_set, btn_next, btn_inc, ovf_in} = '0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got no finish required finish within 100000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    int e, p, r, q, g, t;
    exp_snap(1, ST_IDLE, 2'd0, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // run: ticks 4 and 8 edges after start, pause with prescaler at 2
    e = cyc + 1;
    exp_snap(e, ST_RUN, 2'd0, 1'b0, 1'b0, 1'b0);
    exp_strobe(e + 4, K_CE, 4'd0, 4'd0);
    exp_strobe(e + 8, K_CE, 4'd0, 4'd0);
    press(B_START);
    wait_until(e + 10);
    p = cyc + 1;
    exp_snap(p, ST_PAUSE, 2'd0, 1'b0, 1'b0, 1'b0);
    press(B_START);
    wait_until(p + 10);
    r = cyc + 1;
    exp_snap(r, ST_RUN, 2'd0, 1'b0, 1'b0, 1'b0);
    exp_strobe(r + 2, K_CE, 4'd0, 4'd0);
    press(B_START);
    // overflow on the edge a tick would have fired: pause, no tick
    wait_until(r + 5);
    exp_snap(r + 6, ST_PAUSE, 2'd0, 1'b0, 1'b0, 1'b0);
    press(B_OVF);
    repeat (3) @(negedge clk);
    t = cyc + 1;
    exp_strobe(t, K_CLR, 4'd0, 4'd0);
    exp_snap(t, ST_IDLE, 2'd0, 1'b0, 1'b0, 1'b0);
    press(B_CLEAR | B_START);
    t = cyc + 1;
    exp_strobe(t, K_CLR, 4'd0, 4'd0);
    exp_snap(t, ST_IDLE, 2'd0, 1'b0, 1'b0, 1'b0);
    press(B_CLEAR);

    // set mode editing
    exp_snap(cyc + 1, ST_SET, 2'd0, 1'b1, 1'b0, 1'b0);
    press(B_SET);
    repeat (3) press(B_INC);
    t = cyc + 1;
    exp_strobe(t, K_LD, 4'b0001, 4'd3);
    exp_snap(t, ST_SET, 2'd1, 1'b1, 1'b0, 1'b0);
    press(B_NEXT);
    repeat (11) press(B_INC);
    t = cyc + 1;
    exp_strobe(t, K_LD, 4'b0010, 4'd1);
    exp_snap(t, ST_SET, 2'd2, 1'b1, 1'b0, 1'b0);
    press(B_NEXT);
    repeat (9) press(B_INC);
    exp_snap(cyc + 1, ST_SET, 2'd2, 1'b1, 1'b0, 1'b0);
    press(B_START);
    t = cyc + 1;
    exp_strobe(t, K_LD, 4'b0100, 4'd9);
    exp_snap(t, ST_SET, 2'd3, 1'b1, 1'b0, 1'b0);
    press(B_NEXT);
    t = cyc + 1;
    exp_strobe(t, K_LD, 4'b1000, 4'd0);
    exp_snap(t, ST_SET, 2'd0, 1'b1, 1'b0, 1'b0);
    press(B_NEXT);
    repeat (2) press(B_INC);
    exp_snap(cyc + 1, ST_SET, 2'd0, 1'b1, 1'b0, 1'b0);
    press(B_CLEAR);
    t = cyc + 1;
    exp_strobe(t, K_LD, 4'b0001, 4'd0);
    exp_snap(t, ST_SET, 2'd1, 1'b1, 1'b0, 1'b0);
    press(B_NEXT);
    repeat (5) press(B_INC);
    exp_snap(cyc + 1, ST_PAUSE, 2'd0, 1'b0, 1'b0, 1'b0);
    press(B_SET);
    exp_snap(cyc + 1, ST_SET, 2'd0, 1'b1, 1'b0, 1'b0);
    press(B_SET);
    exp_snap(cyc + 1, ST_PAUSE, 2'd0, 1'b0, 1'b0, 1'b0);
    press(B_SET);

    // reset mid-RUN, one edge before a tick is due
    q = cyc + 1;
    exp_snap(q, ST_RUN, 2'd0, 1'b0, 1'b0, 1'b0);
    press(B_START);
    wait_until(q + 2);
    exp_snap(q + 4, ST_IDLE, 2'd0, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // reset mid-SET with a non-zero digit pointer
    press(B_SET);
    press(B_INC);
    t = cyc + 1;
    exp_strobe(t, K_LD, 4'b0001, 4'd1);
    exp_snap(t, ST_SET, 2'd1, 1'b1, 1'b0, 1'b0);
    press(B_NEXT);
    press(B_INC);
    exp_snap(cyc + 1, ST_IDLE, 2'd0, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_snap(cyc + 1, ST_IDLE, 2'd0, 1'b1, 1'b0, 1'b0);
    press(B_NEXT);
    press(B_INC);

    // lap hold while running; ticks continue
    g = cyc + 1;
    exp_snap(g, ST_RUN, 2'd0, 1'b0, 1'b0, 1'b0);
    exp_strobe(g + 4, K_CE, 4'd0, 4'd0);
    exp_strobe(g + 8, K_CE, 4'd0, 4'd0);
    press(B_START);
    wait_until(g + 1);
    exp_snap(g + 2, ST_RUN, 2'd0, 1'b0, LAP, 1'b0);
    press(B_NEXT);
    wait_until(g + 5);
    exp_snap(g + 6, ST_RUN, 2'd0, 1'b0, 1'b0, 1'b0);
    press(B_NEXT);
    wait_until(g + 9);
    t = cyc + 1;
    exp_strobe(t, K_CLR, 4'd0, 4'd0);
    exp_snap(t, ST_IDLE, 2'd0, 1'b0, 1'b0, 1'b0);
    press(B_CLEAR);
    repeat (6) @(negedge clk);

    finish_req = 1'b1;
    for (int i = 0; i < 5 && !done; i++) @(negedge clk);
    if (!done) begin
      $display("FAIL monitor_done got 0 required 1");
      $fatal(1, "monitor did not complete");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Central sequencer for the stopwatch digit-counter chain. Converts user button pulses into run/pause/clear/set control. Generates the divided count-enable tick that drives the least-significant digit counter. In set mode, produces per-digit load strobes and values for the counters' parallel-load inputs. Sits between the debounced button logic and the digit counters.

Parameters:
TICK_DIV, 100, clk cycles per count tick (>=2)
NUM_DIGITS, 4, number of loadable digit counters (2..8)
DIGIT_MAX, 9, maximum value of an edit digit
STOP_ON_OVF, 1, 1 = enter PAUSE when the chain overflow input asserts during RUN; 0 = ignore it

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_start  in  1  single-cycle pulse; toggles RUN/PAUSE
btn_clear  in  1  single-cycle pulse; clear counters
btn_set  in  1  single-cycle pulse; enter or leave SET
btn_next  in  1  pulse; in SET, commit the current digit and advance
btn_inc  in  1  pulse; in SET, increment the edit value
ovf_in  in  1  carry-out of the most-significant digit counter
count_en  out  1  one-cycle tick to the LSD counter
clr  out  1  one-cycle clear strobe to all counters
load_stb  out  1  one-cycle load strobe
load_sel  out  NUM_DIGITS  one-hot target digit; valid with load_stb
load_val  out  4  value to load; valid with load_stb
digit_ptr  out  $clog2(NUM_DIGITS)  digit currently being edited
state  out  2  IDLE=0, RUN=1, PAUSE=2, SET=3
disp_hold  out  1  freeze display (LAP_EN only; tied 0 otherwise)

Behaviour:
- All outputs are registered. Reset is synchronous and active-high; it takes effect on the rising edge of clk.
- Reset values: state=IDLE, prescaler=0, count_en=0, clr=0, load_stb=0, load_sel=0, load_val=0, digit_ptr=0, edit_val=0, disp_hold=0.
- Priority for same-cycle events: reset > btn_clear > btn_set > btn_start > ovf_in > btn_next > btn_inc. Only the highest-priority event acts; all others are dropped.
- Prescaler:
  - Counts only in RUN. Range 0..TICK_DIV-1.
  - When it reaches TICK_DIV-1, count_en=1 on the next cycle and the prescaler wraps to 0.
  - Holds its value in PAUSE. Zeroed on clear and on the IDLE->RUN transition.
- count_en is 0 in every state other than RUN.
- IDLE:
  - btn_start -> RUN.
  - btn_set -> SET with digit_ptr=0, edit_val=0.
  - btn_clear -> clr pulse; stays IDLE.
- RUN:
  - btn_start -> PAUSE.
  - btn_clear -> clr pulse, prescaler=0, -> IDLE.
  - btn_set is ignored.
  - ovf_in=1 with STOP_ON_OVF=1 -> PAUSE. No count_en is issued in the transition cycle.
- PAUSE:
  - btn_start -> RUN, prescaler resumes from its held value.
  - btn_clear -> clr pulse, -> IDLE.
  - btn_set -> SET with digit_ptr=0, edit_val=0.
- SET:
  - btn_inc: edit_val = (edit_val==DIGIT_MAX) ? 0 : edit_val+1.
  - btn_next: on the next cycle load_stb=1, load_sel=1<<digit_ptr, load_val=edit_val. Then digit_ptr wraps from NUM_DIGITS-1 to 0 and edit_val=0.
  - btn_clear: edit_val=0. No clr pulse is issued.
  - btn_set: -> PAUSE. The uncommitted edit_val is discarded and nothing is loaded.
  - btn_start is ignored.
- clr, load_stb and count_en are mutually exclusive in any cycle.
- Reset asserted mid-RUN or mid-SET aborts immediately. No strobe is issued in the reset cycle or the following cycle.

Optional Feature:
LAP_EN
- Defined: in RUN, btn_next toggles disp_hold; counting continues unaffected. disp_hold clears on btn_clear, on entering SET, and on reset.
- Undefined: disp_hold is tied 0 and btn_next is ignored outside SET.

Test Plan:
- TICK_DIV=4; reset, btn_start -> state=1; count_en pulses every 4th cycle, first pulse 4 cycles after entering RUN.
- RUN for 6 cycles, btn_start, wait 10 cycles, btn_start -> no count_en during PAUSE; next pulse lands exactly 2 cycles after resume.
- IDLE, btn_set, 3x btn_inc, btn_next -> load_stb=1, load_sel=4'b0001, load_val=3; then digit_ptr=1, edit_val=0.
- SET, edit_val=9 (DIGIT_MAX), btn_inc -> edit_val=0; btn_next on digit 3 -> digit_ptr wraps to 0.
- RUN with ovf_in=1 (STOP_ON_OVF=1) -> state=2 next cycle, no count_en; btn_clear and btn_start in the same cycle -> clr=1, state=0.
- LAP_EN: RUN, btn_next -> disp_hold=1 while count_en keeps pulsing; btn_next again -> disp_hold=0.
